// File: rtl/morph_3x3_pkg.sv
// Shared constants and types for the streaming 3x3 morphology filter.
package morph_3x3_pkg;

   localparam int WORD_SIZE  = 8;
   localparam int IMG_WIDTH  = 4;
   localparam int IMG_HEIGHT = 3;

   localparam int MODE_ERODE  = 0;
   localparam int MODE_DILATE = 1;

   typedef struct packed {
      logic sof;
      logic eol;
      logic eof;
   } flags_t;

endpackage

// File: rtl/morph_3x3_line_buffer.sv
// One-row delay line: dout is the word written IMG_W shifts earlier.
module line_buffer #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    ptr;

   assign dout = mem[ptr];

   always_ff @(posedge clk) begin
      if (en)
         mem[ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset)
         ptr <= '0;
      else if (en)
         ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   end

endmodule

// File: rtl/morph_3x3.sv
// Streaming 3x3 erosion/dilation with two line buffers and a drain flush.
module morph_3x3
   import morph_3x3_pkg::*;
#(
   parameter int WIDTH = WORD_SIZE,
   parameter int IMG_W = IMG_WIDTH,
   parameter int IMG_H = IMG_HEIGHT,
   parameter int MODE  = MODE_ERODE
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sof,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_sof,
   output logic             out_eol,
   output logic             out_eof
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] STREAM = 2'd1;
   localparam logic [1:0] FLUSH  = 2'd2;

   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H + 2);

   localparam logic [WIDTH-1:0] PAD =
      (MODE == MODE_ERODE) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

   function automatic logic [WIDTH-1:0] min4(
      input logic [WIDTH-1:0] a, b, c, d);
      logic [WIDTH-1:0] p, q;
      p = (a < b) ? a : b;
      q = (c < d) ? c : d;
      return (p < q) ? p : q;
   endfunction

   function automatic logic [WIDTH-1:0] max4(
      input logic [WIDTH-1:0] a, b, c, d);
      logic [WIDTH-1:0] p, q;
      p = (a > b) ? a : b;
      q = (c > d) ? c : d;
      return (p > q) ? p : q;
   endfunction

   function automatic logic [WIDTH-1:0] red4(
      input logic [WIDTH-1:0] a, b, c, d);
      return (MODE == MODE_ERODE) ? min4(a, b, c, d)
                                  : max4(a, b, c, d);
   endfunction

   function automatic logic [WIDTH-1:0] tap(
      input logic [WIDTH-1:0] v, input logic m);
      return m ? PAD : v;
   endfunction

   logic [1:0]       state;
   logic [XW-1:0]    in_x, cx;
   logic [YW-1:0]    in_y, cy;
   logic [XW:0]      fcnt;
   logic [WIDTH-1:0] s0 [2];
   logic [WIDTH-1:0] s1 [2];
   logic [WIDTH-1:0] s2 [2];
   logic [WIDTH-1:0] lb1_out, lb2_out;
   logic [WIDTH-1:0] pix, res, red_a, red_b;
   logic             accept, flush_step, step;
   logic             abort, last_in, last_flush, warm, emit;
   logic             ml, mr, mt, mb;
   flags_t           flags;

   assign in_ready   = (state != FLUSH);
   assign accept     = in_valid & in_ready;
   assign flush_step = (state == FLUSH);
   assign step       = accept | flush_step;
   assign pix        = flush_step ? PAD : in_data;

   assign abort = accept && in_sof && (state == STREAM) &&
                  !(in_x == '0 && in_y == '0);
   assign last_in = (in_x == XW'(IMG_W - 1)) &&
                    (in_y == YW'(IMG_H - 1));
   assign last_flush = (fcnt == (XW + 1)'(IMG_W));

   // The newest stream index must be at least IMG_W+1 for a centre to exist.
   assign warm = (in_y > YW'(1)) ||
                 (in_y == YW'(1) && in_x != '0);
   assign emit = step && !abort && warm;

   line_buffer #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_lb1 (
      .clk   (clk),
      .reset (reset),
      .en    (step),
      .din   (pix),
      .dout  (lb1_out)
   );

   line_buffer #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_lb2 (
      .clk   (clk),
      .reset (reset),
      .en    (step),
      .din   (lb1_out),
      .dout  (lb2_out)
   );

   always_ff @(posedge clk) begin
      if (step) begin
         s0[0] <= pix;
         s0[1] <= s0[0];
         s1[0] <= lb1_out;
         s1[1] <= s1[0];
         s2[0] <= lb2_out;
         s2[1] <= s2[0];
      end
   end

   // Masking by centre coordinates also blocks row wrap in the linear stream.
   assign ml = (cx == '0);
   assign mr = (cx == XW'(IMG_W - 1));
   assign mt = (cy == '0);
   assign mb = (cy == YW'(IMG_H - 1));

   assign red_a = red4(tap(s2[1], mt | ml), tap(s2[0], mt),
                       tap(lb2_out, mt | mr), tap(s1[1], ml));
   assign red_b = red4(tap(lb1_out, mr), tap(s0[1], mb | ml),
                       tap(s0[0], mb), tap(pix, mb | mr));
   assign res   = red4(red_a, red_b, s1[0], s1[0]);

   assign flags.sof = (cx == '0) && (cy == '0);
   assign flags.eol = mr;
   assign flags.eof = mr && mb;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         in_x  <= '0;
         in_y  <= '0;
         cx    <= '0;
         cy    <= '0;
         fcnt  <= '0;
      end else begin
         unique case (state)
            IDLE:
               if (accept) state <= STREAM;
            STREAM:
               if (accept && !abort && last_in) state <= FLUSH;
            FLUSH:
               if (last_flush) state <= IDLE;
            default:
               state <= IDLE;
         endcase

         fcnt <= (flush_step && !last_flush) ? fcnt + 1'b1 : '0;

         if (abort) begin
            in_x <= XW'(1);
            in_y <= '0;
         end else if (step) begin
            if (flush_step && last_flush) begin
               in_x <= '0;
               in_y <= '0;
            end else if (in_x == XW'(IMG_W - 1)) begin
               in_x <= '0;
               in_y <= in_y + 1'b1;
            end else begin
               in_x <= in_x + 1'b1;
            end
         end

         if (abort) begin
            cx <= '0;
            cy <= '0;
         end else if (emit) begin
            if (mr) begin
               cx <= '0;
               cy <= mb ? '0 : cy + 1'b1;
            end else begin
               cx <= cx + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sof   <= 1'b0;
         out_eol   <= 1'b0;
         out_eof   <= 1'b0;
      end else begin
         out_valid <= emit;
         if (emit) begin
            out_data <= res;
            out_sof  <= flags.sof;
            out_eol  <= flags.eol;
            out_eof  <= flags.eof;
         end
      end
   end

endmodule

// File: tb/tb_morph_3x3.sv
// Scoreboard bench for morph_3x3: erosion and dilation instances on a 4x3 frame.
module tb_morph_3x3;
   import morph_3x3_pkg::*;

   localparam int W = 4;
   localparam int H = 3;
   localparam int N = W * H;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ve = 1'b0, se = 1'b0, vd = 1'b0, sd = 1'b0;
   logic [7:0] de = '0, dd = '0;
   logic       re, ove, osfe, eole, eofe;
   logic       rd, ovd, osfd, eold, eofd;
   logic [7:0] ode, odd;

   morph_3x3 #(.WIDTH(8), .IMG_W(W), .IMG_H(H), .MODE(0)) dut_e (
      .clk(clk), .reset(reset),
      .in_valid(ve), .in_ready(re), .in_data(de), .in_sof(se),
      .out_valid(ove), .out_data(ode), .out_sof(osfe),
      .out_eol(eole), .out_eof(eofe)
   );

   morph_3x3 #(.WIDTH(8), .IMG_W(W), .IMG_H(H), .MODE(1)) dut_d (
      .clk(clk), .reset(reset),
      .in_valid(vd), .in_ready(rd), .in_data(dd), .in_sof(sd),
      .out_valid(ovd), .out_data(odd), .out_sof(osfd),
      .out_eol(eold), .out_eof(eofd)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int acc_e = 0;
   int sof_acc = -1;
   bit pend_e = 1'b0, pend_d = 1'b0;
   logic [10:0] qe[$];
   logic [10:0] qd[$];
   logic [7:0] e1_in [N];
   logic [7:0] e1_ex [N];
   logic [7:0] d1_in [N];
   logic [7:0] d1_ex [N];

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic logic [10:0] expv(input int i, input logic [7:0] v);
      return {i == 0, (i % W) == W - 1, i == N - 1, v};
   endfunction

   always @(negedge clk) begin
      if (ove) begin
         chk("e_after_step", int'(pend_e), 1);
         if (qe.size() == 0) begin
            chk("e_unexpected_out", 1, 0);
         end else begin
            chk("e_out", int'({osfe, eole, eofe, ode}), int'(qe.pop_front()));
         end
         if (osfe && sof_acc < 0) sof_acc = acc_e;
      end
      if (ovd) begin
         chk("d_after_step", int'(pend_d), 1);
         if (qd.size() == 0) begin
            chk("d_unexpected_out", 1, 0);
         end else begin
            chk("d_out", int'({osfd, eold, eofd, odd}), int'(qd.pop_front()));
         end
      end
      pend_e = (ve & re) | !re;
      pend_d = (vd & rd) | !rd;
      if (ve & re) acc_e++;
   end

   task automatic send(input bit dsel, input logic [7:0] px, input bit sof);
      bit ok;
      ok = 1'b0;
      if (dsel) begin vd = 1'b1; dd = px; sd = sof; end
      else      begin ve = 1'b1; de = px; se = sof; end
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge clk);
         ok = dsel ? rd : re;
      end
      if (!ok) chk("ready_timeout", 0, 1);
      @(posedge clk);
      #1;
      ve = 1'b0; se = 1'b0;
      vd = 1'b0; sd = 1'b0;
   endtask

   task automatic frame(input bit dsel, input logic [7:0] px [N],
                        input int first, input int last, input int gap);
      for (int i = first; i <= last; i++) begin
         send(dsel, px[i], i == first);
         repeat (gap) begin @(posedge clk); #1; end
      end
   endtask

   task automatic push(input bit dsel, input logic [7:0] ex [N]);
      for (int i = 0; i < N; i++) begin
         if (dsel) qd.push_back(expv(i, ex[i]));
         else      qe.push_back(expv(i, ex[i]));
      end
   endtask

   initial begin
      int cnt;
      for (int i = 0; i < N; i++) begin
         e1_in[i] = (i == 5) ? 8'd0 : 8'd255;
         e1_ex[i] = ((i % W) == 3) ? 8'd255 : 8'd0;
         d1_in[i] = (i == 11) ? 8'd255 : 8'd0;
         d1_ex[i] = (i == 6 || i == 7 || i == 10 || i == 11) ? 8'd255 : 8'd0;
      end

      repeat (3) @(posedge clk);
      #1;
      chk("rst_e_valid", int'(ove), 0);
      chk("rst_e_data", int'(ode), 0);
      chk("rst_e_flags", int'({osfe, eole, eofe}), 0);
      chk("rst_e_ready", int'(re), 1);
      chk("rst_d_valid", int'(ovd), 0);
      chk("rst_d_ready", int'(rd), 1);
      reset = 1'b0;

      push(0, e1_ex);
      frame(0, e1_in, 0, N - 1, 0);
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (re) break;
         cnt++;
      end
      chk("flush_ready_low", cnt, W + 1);
      chk("first_sof_accept", sof_acc, W + 2);

      push(1, d1_ex);
      frame(1, d1_in, 0, N - 1, 0);
      repeat (10) @(posedge clk);
      #1;

      push(0, e1_ex);
      frame(0, e1_in, 0, N - 1, 1);

      qe.push_back(expv(0, e1_ex[0]));
      qe.push_back(expv(1, e1_ex[1]));
      push(0, e1_ex);
      frame(0, e1_in, 0, 6, 0);
      frame(0, e1_in, 0, N - 1, 0);

      qe.push_back(expv(0, e1_ex[0]));
      qe.push_back(expv(1, e1_ex[1]));
      frame(0, e1_in, 0, 6, 0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("midrst_valid", int'(ove), 0);
      chk("midrst_ready", int'(re), 1);
      push(0, e1_ex);
      frame(0, e1_in, 0, N - 1, 0);

      for (int k = 0; k < 100 && (qe.size() != 0 || qd.size() != 0); k++)
         @(negedge clk);
      chk("e_queue_drained", qe.size(), 0);
      chk("d_queue_drained", qd.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
